axis_frame_tx: RTL and testbench

AXIS_FRAME_TX -- requirements
Module: axis_frame_tx

---
 rtl/axis_frame_tx.sv | 167 ++++++++++++++++
 tb/tb_axis_frame_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_tx.sv
// axis_frame_tx: frame buffer replayed as an AXI-Stream frame through a 2-entry prefetch/skid stage.
// Define AXIS_FRAME_TX_ABORT_EN to enable abort with a tuser bad-frame marker on the closing beat.
module axis_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_count
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  localparam logic [LEN_WIDTH-1:0] DEPTH_LEN = LEN_WIDTH'(DEPTH);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg, rd_last_reg;
  logic [LEN_WIDTH-1:0]  rd_addr_reg, len_reg;
  logic [DATA_WIDTH-1:0] skid_data_reg;
  logic                  skid_valid_reg, skid_last_reg;
  logic [DATA_WIDTH-1:0] tdata_reg;
  logic                  tvalid_reg, tlast_reg, tuser_reg, done_reg;
  logic [15:0]           frame_count_reg;
  logic                  abort_pend_reg, mark_done_reg;

  logic                  pop, more, credit, issue, abort_hit, abort_act, mark;
  logic [1:0]            occ;
  logic [LEN_WIDTH-1:0]  len_clamped;

`ifdef AXIS_FRAME_TX_ABORT_EN
  assign abort_hit = abort && (state_reg != IDLE);
`else
  assign abort_hit = abort & 1'b0;
`endif

  assign pop         = tvalid_reg && m_axis_tready;
  assign more        = (rd_addr_reg != len_reg);
  // Words held or landing after this edge; a new read may only be issued if it
  // can still be absorbed next cycle even if the sink stalls.
  assign occ         = {1'b0, tvalid_reg} + {1'b0, skid_valid_reg} + {1'b0, rd_valid_reg} - {1'b0, pop};
  assign credit      = (occ <= 2'd1);
  assign abort_act   = abort_pend_reg || abort_hit;
  assign mark        = abort_act && !mark_done_reg;
  assign issue       = (state_reg != IDLE) && more && credit &&
                       (!abort_act || (!mark_done_reg && !skid_valid_reg && !rd_valid_reg));
  assign len_clamped = (frame_len > DEPTH_LEN) ? DEPTH_LEN : frame_len;

  // Buffer: writes only while idle, registered read.
  always_ff @(posedge clk) begin
    if (wr_en && state_reg == IDLE)
      mem[wr_addr] <= wr_data;
    if (issue)
      rd_data_reg <= mem[rd_addr_reg[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rd_valid_reg    <= 1'b0;
      rd_last_reg     <= 1'b0;
      rd_addr_reg     <= '0;
      len_reg         <= '0;
      skid_data_reg   <= '0;
      skid_valid_reg  <= 1'b0;
      skid_last_reg   <= 1'b0;
      tdata_reg       <= '0;
      tvalid_reg      <= 1'b0;
      tlast_reg       <= 1'b0;
      tuser_reg       <= 1'b0;
      done_reg        <= 1'b0;
      frame_count_reg <= '0;
      abort_pend_reg  <= 1'b0;
      mark_done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        rd_valid_reg <= 1'b0;
        if (start && frame_len != '0) begin
          state_reg      <= FETCH;
          len_reg        <= len_clamped;
          rd_addr_reg    <= '0;
          abort_pend_reg <= 1'b0;
          mark_done_reg  <= 1'b0;
        end
      end else begin
        rd_valid_reg <= issue;
        if (issue) begin
          rd_addr_reg <= rd_addr_reg + 1'b1;
          rd_last_reg <= (rd_addr_reg == len_reg - 1'b1);
        end
        if (abort_hit)
          abort_pend_reg <= 1'b1;
        if (state_reg == FETCH && rd_valid_reg)
          state_reg <= SEND;

        if (!tvalid_reg || pop) begin
          // The first beat loaded after an abort closes the frame; anything behind it is dropped.
          if (skid_valid_reg) begin
            tdata_reg  <= skid_data_reg;
            tlast_reg  <= skid_last_reg || mark;
            tuser_reg  <= mark;
            tvalid_reg <= 1'b1;
            if (rd_valid_reg && !mark) begin
              skid_data_reg <= rd_data_reg;
              skid_last_reg <= rd_last_reg;
            end else begin
              skid_valid_reg <= 1'b0;
            end
          end else if (rd_valid_reg) begin
            tdata_reg  <= rd_data_reg;
            tlast_reg  <= rd_last_reg || mark;
            tuser_reg  <= mark;
            tvalid_reg <= 1'b1;
          end else begin
            tvalid_reg <= 1'b0;
          end
          if ((skid_valid_reg || rd_valid_reg) && mark)
            mark_done_reg <= 1'b1;
        end else if (rd_valid_reg) begin
          skid_valid_reg <= 1'b1;
          skid_data_reg  <= rd_data_reg;
          skid_last_reg  <= rd_last_reg;
        end else if (mark && !skid_valid_reg && !more) begin
          // Nothing left behind the stalled beat, so it becomes the marked closing beat.
          tlast_reg     <= 1'b1;
          tuser_reg     <= 1'b1;
          mark_done_reg <= 1'b1;
        end

        if (pop && tlast_reg) begin
          state_reg       <= IDLE;
          done_reg        <= 1'b1;
          frame_count_reg <= frame_count_reg + 16'd1;
          tvalid_reg      <= 1'b0;
          skid_valid_reg  <= 1'b0;
          rd_valid_reg    <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tuser  = tuser_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed self-checking bench for axis_frame_tx: latency, backpressure, abort, length limits, reset.
`timescale 1ns/1ps
module tb_axis_frame_tx;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LW    = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic          abort = 1'b0;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tuser, busy, done;
  logic [15:0]   frame_count;

  axis_frame_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .frame_len(frame_len), .abort(abort),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .m_axis_tready(tready), .busy(busy), .done(done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Beat monitor, sampled on the falling edge.
  logic [DW-1:0] q_data[$];
  bit            q_last[$];
  bit            q_user[$];
  int            q_cyc[$];
  logic [DW-1:0] exp_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  bit            stall_prev = 1'b0;
  logic [DW+2:0] snap_prev = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_stable", {tvalid, tlast, tuser, tdata}, snap_prev);
      if (tvalid && tready) begin
        q_data.push_back(tdata);
        q_last.push_back(tlast);
        q_user.push_back(tuser);
        q_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = tvalid && !tready;
      snap_prev  = {tvalid, tlast, tuser, tdata};
    end
  end

  task automatic clear_mon();
    q_data.delete(); q_last.delete(); q_user.delete(); q_cyc.delete(); exp_q.delete();
  endtask

  task automatic start_frame(input int len, output int a);
    @(posedge clk); #1;
    start = 1'b1; frame_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    a = cyc;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, done_cnt - d0, 1);
    @(negedge clk);
    check({tag, "_done_width"}, done, 0);
    @(posedge clk); #1;
  endtask

  task automatic accept_one();
    int k = 0;
    while (!tvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1 tready = 1'b1;
    @(posedge clk); #1 tready = 1'b0;
  endtask

  task automatic verify(input string tag, input int n, input int user_cnt);
    int errs = 0;
    int nl = 0;
    int nu = 0;
    check({tag, "_count"}, q_data.size(), n);
    for (int i = 0; i < q_data.size(); i++) begin
      if (i >= exp_q.size() || q_data[i] !== exp_q[i]) errs++;
      nl += int'(q_last[i]);
      nu += int'(q_user[i]);
    end
    check({tag, "_data"}, errs, 0);
    check({tag, "_tlast_count"}, nl, 1);
    if (q_last.size() > 0) check({tag, "_tlast_pos"}, q_last[q_last.size()-1], 1);
    check({tag, "_tuser"}, nu, user_cnt);
    $display("frame %s: %0d beats, %0d tlast, %0d tuser", tag, q_data.size(), nl, nu);
  endtask

  initial begin
    int a, d0, k, act;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tuser", tuser, 0);
    check("rst_tdata", tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_count", frame_count, 0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
    end
    @(posedge clk); #1 wr_en = 1'b0;

    // Basic 10-word frame, full throughput, plus a write attempt while busy.
    clear_mon();
    for (int i = 0; i < 10; i++) exp_q.push_back(DW'(i));
    tready = 1'b1;
    d0 = done_cnt;
    start_frame(10, a);
    wr_en = 1'b1; wr_addr = '0; wr_data = 8'hFF;
    @(negedge clk); check("t1_valid_c0", tvalid, 0);
    check("t1_busy", busy, 1);
    @(negedge clk); check("t1_valid_c1", tvalid, 0);
    wr_en = 1'b0;
    @(negedge clk); check("t1_valid_c2", tvalid, 1);
    wait_done("t1", d0, 50);
    verify("t1", 10, 0);
    if (q_cyc.size() == 10) begin
      check("t1_first_beat_cyc", q_cyc[0] - a, 2);
      check("t1_last_beat_cyc", q_cyc[9] - a, 11);
    end
    check("t1_done_cyc", done_cyc - a, 12);
    check("t1_frame_count", frame_count, 1);
    check("t1_busy_after", busy, 0);

    // 784 words with random backpressure.
    clear_mon();
    for (int i = 0; i < 784; i++) exp_q.push_back(DW'(i));
    tready = 1'b0;
    d0 = done_cnt;
    start_frame(784, a);
    k = 0;
    while (done_cnt == d0 && k < 6000) begin
      @(posedge clk); #1 tready = 1'($urandom_range(0, 1));
      k++;
    end
    tready = 1'b1;
    wait_done("t2", d0, 10);
    verify("t2", 784, 0);
    check("t2_frame_count", frame_count, 2);

    // Abort while beat 5 of a 20-word frame is stalled.
    clear_mon();
    tready = 1'b0;
    d0 = done_cnt;
    start_frame(20, a);
    for (int b = 0; b < 5; b++) accept_one();
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t3_stalled_valid", tvalid, 1);
    check("t3_stalled_data", tdata, 5);
    check("t3_stalled_tlast", tlast, 0);
    check("t3_stalled_tuser", tuser, 0);
    @(posedge clk); #1 tready = 1'b1;
    wait_done("t3", d0, 60);
`ifdef AXIS_FRAME_TX_ABORT_EN
    for (int i = 0; i < 7; i++) exp_q.push_back(DW'(i));
    verify("t3", 7, 1);
    if (q_user.size() == 7) check("t3_tuser_pos", q_user[6], 1);
`else
    for (int i = 0; i < 20; i++) exp_q.push_back(DW'(i));
    verify("t3", 20, 0);
`endif
    check("t3_frame_count", frame_count, 3);

    // Zero length is ignored; oversize length clamps to DEPTH.
    clear_mon();
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; frame_len = '0;
    @(posedge clk); #1 start = 1'b0;
    act = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || tvalid) act++;
    end
    check("t4_zero_len_activity", act, 0);
    check("t4_zero_len_done", done_cnt - d0, 0);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(DW'(i));
    @(posedge clk); #1;
    start_frame(4096, a);
    wait_done("t4", d0, 2000);
    verify("t4", DEPTH, 0);
    check("t4_frame_count", frame_count, 4);

    // Reset in the middle of a 200-word frame, then a short frame with a start-cycle write.
    clear_mon();
    tready = 1'b1;
    start_frame(200, a);
    k = 0;
    while (q_data.size() < 100 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("t5_reached_beat100", q_data.size() >= 100, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t5_rst_tvalid", tvalid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_tlast", tlast, 0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    check("t5_rst_no_done", done_cnt - d0, 0);
    check("t5_rst_frame_count", frame_count, 0);
    act = 0;
    for (int i = 0; i < q_last.size(); i++) act += int'(q_last[i]);
    check("t5_cut_no_tlast", act, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    clear_mon();
    exp_q.push_back(8'h00); exp_q.push_back(8'hAB); exp_q.push_back(8'h02);
    d0 = done_cnt;
    start = 1'b1; frame_len = LW'(3);
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = 8'hAB;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    wait_done("t5", d0, 50);
    verify("t5", 3, 0);
    check("t5_frame_count", frame_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
